// File: rtl/sdram_init_checker.sv
// sdram_init_checker
// Passive monitor for the SDRAM power-up / initialisation command sequence.
// It watches the command, address and bank buses and checks the sequence
// below, including the minimum gap in clock cycles between commands:
//   power-up wait -> PRE-all -> AREF x N -> LMR -> tMRD
// On success init_ok and mode_valid go high and mode_reg holds the
// programmed mode word. On the first violation init_err goes high,
// err_code records the violation, and the checker freezes until reset.
//
// Violation codes:
//   1 command issued before the power-up wait elapsed
//   2 first command was not PRE-all
//   3 tRP violated
//   4 tRFC violated
//   5 LMR issued with too few AREFs
//   6 tMRD violated
//   7 illegal command for the current phase
module sdram_init_checker #(
  parameter int unsigned POW_CYC  = 33445,
  parameter int unsigned RP_CYC   = 4,
  parameter int unsigned RFC_CYC  = 12,
  parameter int unsigned MRD_CYC  = 6,
  parameter int unsigned AREF_MIN = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [3:0]  cmd_in,
  input  logic [12:0] addr_in,
  input  logic [1:0]  ba_in,
  output logic        init_ok,
  output logic        init_err,
  output logic [2:0]  err_code,
  output logic [3:0]  aref_cnt,
  output logic [12:0] mode_reg,
  output logic        mode_valid
);

  // Checker phases. CK_AREF is a reserved encoding that is never entered.
  localparam logic [2:0] CK_POW  = 3'd0;
  localparam logic [2:0] CK_PRE  = 3'd1;
  localparam logic [2:0] CK_TRP  = 3'd2;
  localparam logic [2:0] CK_AREF = 3'd3;
  localparam logic [2:0] CK_TRFC = 3'd4;
  localparam logic [2:0] CK_TMRD = 3'd5;
  localparam logic [2:0] CK_DONE = 3'd6;
  localparam logic [2:0] CK_ERR  = 3'd7;

  // Command encodings on {cs_n, ras_n, cas_n, we_n}.
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_LMR  = 4'b0000;

  // Violation codes.
  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_POW   = 3'd1;
  localparam logic [2:0] ERR_FIRST = 3'd2;
  localparam logic [2:0] ERR_TRP   = 3'd3;
  localparam logic [2:0] ERR_TRFC  = 3'd4;
  localparam logic [2:0] ERR_AREFN = 3'd5;
  localparam logic [2:0] ERR_TMRD  = 3'd6;
  localparam logic [2:0] ERR_ILL   = 3'd7;

  // Gap minimums at the width of the gap counter. The counter saturates
  // at 16 bits, so the minimums are taken at the same width.
  localparam logic [15:0] POW_MIN  = 16'(POW_CYC);
  localparam logic [15:0] RP_MIN   = 16'(RP_CYC);
  localparam logic [15:0] RFC_MIN  = 16'(RFC_CYC);
  localparam logic [15:0] MRD_MIN  = 16'(MRD_CYC);
  localparam logic [3:0]  AREF_REQ = 4'(AREF_MIN);

  // A deselected chip (cs_n high) or an explicit NOP carries no command.
  function automatic logic is_nop(input logic [3:0] cmd);
    return cmd[3] | (cmd[2:0] == 3'b111);
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Increment that sticks at 15 instead of wrapping.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  logic [2:0]  state_r;
  logic [15:0] gap_r;
  logic        init_ok_r;
  logic        init_err_r;
  logic [2:0]  err_code_r;
  logic [3:0]  aref_cnt_r;
  logic [12:0] mode_reg_r;
  logic        mode_valid_r;

  logic        cmd_valid_s;
  logic [2:0]  state_step_s;
  logic [2:0]  state_nxt_s;
  logic [2:0]  raise_s;
  logic        aref_inc_s;
  logic        lmr_cap_s;

  assign cmd_valid_s = ~is_nop(cmd_in);

  // Judge the sampled command against the current phase. Checks are ordered
  // so that the lowest-numbered violation wins.
  always_comb begin
    state_step_s = state_r;
    raise_s      = ERR_NONE;
    aref_inc_s   = 1'b0;
    lmr_cap_s    = 1'b0;
    case (state_r)
      CK_POW: begin
        if (cmd_valid_s) begin
          if (gap_r < POW_MIN) begin
            raise_s = ERR_POW;
          end else if ((cmd_in == CMD_PRE) && addr_in[10]) begin
            state_step_s = CK_TRP;
          end else begin
            raise_s = ERR_FIRST;
          end
        end else begin
          state_step_s = CK_POW;
        end
      end
      CK_TRP: begin
        if (cmd_valid_s) begin
          if (gap_r < RP_MIN) begin
            raise_s = ERR_TRP;
          end else if (cmd_in == CMD_AREF) begin
            state_step_s = CK_TRFC;
            aref_inc_s   = 1'b1;
          end else begin
            raise_s = ERR_ILL;
          end
        end else begin
          state_step_s = CK_TRP;
        end
      end
      CK_TRFC: begin
        if (cmd_valid_s) begin
          if (gap_r < RFC_MIN) begin
            raise_s = ERR_TRFC;
          end else if (cmd_in == CMD_AREF) begin
            aref_inc_s = 1'b1;
          end else if (cmd_in == CMD_LMR) begin
            if (aref_cnt_r < AREF_REQ) begin
              raise_s = ERR_AREFN;
            end else if (ba_in != 2'b00) begin
              raise_s = ERR_ILL;
            end else begin
              state_step_s = CK_TMRD;
              lmr_cap_s    = 1'b1;
            end
          end else begin
            raise_s = ERR_ILL;
          end
        end else begin
          state_step_s = CK_TRFC;
        end
      end
      CK_TMRD: begin
        // Once the mode register has settled, whatever arrives is post-init.
        if (gap_r >= MRD_MIN) begin
          state_step_s = CK_DONE;
        end else if (cmd_valid_s) begin
          raise_s = ERR_TMRD;
        end else begin
          state_step_s = CK_TMRD;
        end
      end
      CK_DONE: state_step_s = CK_DONE;
      CK_ERR:  state_step_s = CK_ERR;
      CK_PRE:  state_step_s = CK_POW;
      default: state_step_s = CK_POW;
    endcase
  end

  // Any violation overrides the phase transition.
  always_comb begin
    if (raise_s != ERR_NONE) begin
      state_nxt_s = CK_ERR;
    end else begin
      state_nxt_s = state_step_s;
    end
  end

  // Phase register and inter-command gap counter.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r <= CK_POW;
      gap_r   <= 16'd0;
    end else begin
      state_r <= state_nxt_s;
      if (cmd_valid_s) begin
        gap_r <= 16'd1;
      end else begin
        gap_r <= sat_inc16(gap_r);
      end
    end
  end

  // Registered status outputs; frozen once the checker reaches CK_ERR or CK_DONE.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      init_ok_r    <= 1'b0;
      init_err_r   <= 1'b0;
      err_code_r   <= ERR_NONE;
      aref_cnt_r   <= 4'd0;
      mode_reg_r   <= 13'd0;
      mode_valid_r <= 1'b0;
    end else if ((state_r == CK_ERR) || (state_r == CK_DONE)) begin
      init_ok_r    <= init_ok_r;
      init_err_r   <= init_err_r;
      err_code_r   <= err_code_r;
      aref_cnt_r   <= aref_cnt_r;
      mode_reg_r   <= mode_reg_r;
      mode_valid_r <= mode_valid_r;
    end else begin
      init_ok_r    <= (state_nxt_s == CK_DONE);
      mode_valid_r <= (state_nxt_s == CK_DONE);
      if (raise_s != ERR_NONE) begin
        init_err_r <= 1'b1;
        err_code_r <= raise_s;
      end else begin
        init_err_r <= init_err_r;
        err_code_r <= err_code_r;
      end
      if (aref_inc_s) begin
        aref_cnt_r <= sat_inc4(aref_cnt_r);
      end else begin
        aref_cnt_r <= aref_cnt_r;
      end
      if (lmr_cap_s) begin
        mode_reg_r <= addr_in;
      end else begin
        mode_reg_r <= mode_reg_r;
      end
    end
  end

  assign init_ok    = init_ok_r;
  assign init_err   = init_err_r;
  assign err_code   = err_code_r;
  assign aref_cnt   = aref_cnt_r;
  assign mode_reg   = mode_reg_r;
  assign mode_valid = mode_valid_r;

endmodule

// File: tb/tb_sdram_init_checker.sv
// Directed testbench for sdram_init_checker (POW_CYC shortened to 20).
module tb_sdram_init_checker;

  localparam int POW = 20;

  localparam logic [3:0] C_NOP  = 4'b0111;
  localparam logic [3:0] C_PRE  = 4'b0010;
  localparam logic [3:0] C_AREF = 4'b0001;
  localparam logic [3:0] C_LMR  = 4'b0000;
  localparam logic [3:0] C_ACT  = 4'b0011;
  localparam logic [3:0] C_RD   = 4'b0101;
  localparam logic [3:0] C_WR   = 4'b0100;
  localparam logic [3:0] C_DES  = 4'b1000;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [3:0]  cmd_in  = 4'b0111;
  logic [12:0] addr_in = 13'd0;
  logic [1:0]  ba_in   = 2'd0;
  logic        init_ok, init_err, mode_valid;
  logic [2:0]  err_code;
  logic [3:0]  aref_cnt;
  logic [12:0] mode_reg;

  int n_cmp = 0;
  int n_mis = 0;

  sdram_init_checker #(.POW_CYC(POW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cmd_in(cmd_in), .addr_in(addr_in),
    .ba_in(ba_in), .init_ok(init_ok), .init_err(init_err), .err_code(err_code),
    .aref_cnt(aref_cnt), .mode_reg(mode_reg), .mode_valid(mode_valid)
  );

  always #5 sys_clk = ~sys_clk;

  // Present one command for one rising edge; return 1 time unit after it.
  task automatic step(input logic [3:0] c, input logic [12:0] a, input logic [1:0] b);
    cmd_in = c; addr_in = a; ba_in = b;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step(C_NOP, 13'd0, 2'd0);
  endtask

  // Two reset edges; the next step() samples cycle 0 after release.
  task automatic do_reset();
    sys_rst = 1'b1;
    nops(2);
    sys_rst = 1'b0;
  endtask

  task automatic to_trp();
    do_reset();
    nops(POW);
    step(C_PRE, 13'h400, 2'd0);
  endtask

  task automatic to_trfc(input int n);
    to_trp();
    nops(3);
    step(C_AREF, 13'd0, 2'd0);
    for (int i = 1; i < n; i++) begin
      nops(11);
      step(C_AREF, 13'd0, 2'd0);
    end
  endtask

  // Full legal sequence starting from the first cycle after reset release.
  task automatic nominal_from_release();
    nops(POW);
    step(C_PRE, 13'h400, 2'd0);
    nops(3);
    step(C_AREF, 13'd0, 2'd0);
    for (int i = 1; i < 6; i++) begin
      nops(11);
      step(C_AREF, 13'd0, 2'd0);
    end
    nops(11);
    step(C_LMR, 13'h037, 2'd0);
    nops(6);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (init_ok !== 1'b0) begin n_mis++; $display("FAIL reset_init_ok: observed %0b expected 0", init_ok); end
    n_cmp++; if (init_err !== 1'b0) begin n_mis++; $display("FAIL reset_init_err: observed %0b expected 0", init_err); end
    n_cmp++; if (err_code !== 3'd0) begin n_mis++; $display("FAIL reset_err_code: observed %0d expected 0", err_code); end
    n_cmp++; if (aref_cnt !== 4'd0) begin n_mis++; $display("FAIL reset_aref_cnt: observed %0d expected 0", aref_cnt); end
    n_cmp++; if (mode_reg !== 13'd0) begin n_mis++; $display("FAIL reset_mode_reg: observed %h expected 0", mode_reg); end
    n_cmp++; if (mode_valid !== 1'b0) begin n_mis++; $display("FAIL reset_mode_valid: observed %0b expected 0", mode_valid); end
  endtask

  task automatic test_nominal();
    to_trfc(6);
    nops(11);
    step(C_LMR, 13'h037, 2'd0);
    n_cmp++; if (mode_reg !== 13'h037) begin n_mis++; $display("FAIL nom_mode_reg: observed %h expected 037", mode_reg); end
    n_cmp++; if (aref_cnt !== 4'd6) begin n_mis++; $display("FAIL nom_aref_cnt: observed %0d expected 6", aref_cnt); end
    n_cmp++; if (init_ok !== 1'b0) begin n_mis++; $display("FAIL nom_ok_after_lmr: observed %0b expected 0", init_ok); end
    nops(5);
    n_cmp++; if (init_ok !== 1'b0) begin n_mis++; $display("FAIL nom_ok_gap5: observed %0b expected 0", init_ok); end
    nops(1);
    n_cmp++; if (init_ok !== 1'b1) begin n_mis++; $display("FAIL nom_ok_gap6: observed %0b expected 1", init_ok); end
    n_cmp++; if (mode_valid !== 1'b1) begin n_mis++; $display("FAIL nom_mode_valid: observed %0b expected 1", mode_valid); end
    n_cmp++; if (err_code !== 3'd0) begin n_mis++; $display("FAIL nom_err_code: observed %0d expected 0", err_code); end
    step(C_ACT, 13'd0, 2'd0);
    step(C_PRE, 13'd0, 2'd0);
    n_cmp++; if ({init_ok, init_err} !== 2'b10) begin n_mis++; $display("FAIL nom_done_ignores: observed %b expected 10", {init_ok, init_err}); end
  endtask

  task automatic test_pow();
    do_reset();
    nops(10);
    step(C_PRE, 13'h400, 2'd0);
    n_cmp++; if (init_err !== 1'b1) begin n_mis++; $display("FAIL pow10_err: observed %0b expected 1", init_err); end
    n_cmp++; if (err_code !== 3'd1) begin n_mis++; $display("FAIL pow10_code: observed %0d expected 1", err_code); end
    nops(15);
    step(C_PRE, 13'h400, 2'd0);
    nops(3);
    step(C_AREF, 13'd0, 2'd0);
    n_cmp++; if ({init_ok, init_err, err_code, aref_cnt} !== {1'b0, 1'b1, 3'd1, 4'd0}) begin
      n_mis++; $display("FAIL pow10_hold: observed ok=%0b err=%0b code=%0d cnt=%0d expected ok=0 err=1 code=1 cnt=0", init_ok, init_err, err_code, aref_cnt);
    end
    do_reset();
    nops(19);
    step(C_PRE, 13'h400, 2'd0);
    n_cmp++; if (err_code !== 3'd1) begin n_mis++; $display("FAIL pow19_code: observed %0d expected 1", err_code); end
    do_reset();
    nops(20);
    step(C_AREF, 13'd0, 2'd0);
    n_cmp++; if (err_code !== 3'd2) begin n_mis++; $display("FAIL pow_aref_first: observed %0d expected 2", err_code); end
    do_reset();
    nops(20);
    step(C_PRE, 13'h000, 2'd0);
    n_cmp++; if (err_code !== 3'd2) begin n_mis++; $display("FAIL pow_pre_single: observed %0d expected 2", err_code); end
    do_reset();
    nops(5);
    step(C_DES, 13'd0, 2'd0);
    step(4'b1010, 13'h400, 2'd0);
    nops(13);
    step(C_PRE, 13'h400, 2'd0);
    n_cmp++; if (init_err !== 1'b0) begin n_mis++; $display("FAIL pow_deselect_nop: observed %0b expected 0", init_err); end
  endtask

  task automatic test_trp();
    to_trp();
    nops(3);
    step(C_ACT, 13'd0, 2'd0);
    n_cmp++; if (err_code !== 3'd7) begin n_mis++; $display("FAIL trp_act: observed %0d expected 7", err_code); end
    to_trp();
    nops(2);
    step(C_AREF, 13'd0, 2'd0);
    n_cmp++; if (err_code !== 3'd3) begin n_mis++; $display("FAIL trp_short: observed %0d expected 3", err_code); end
    to_trp();
    nops(1);
    step(C_ACT, 13'd0, 2'd0);
    n_cmp++; if (err_code !== 3'd3) begin n_mis++; $display("FAIL trp_short_act: observed %0d expected 3", err_code); end
  endtask

  task automatic test_trfc();
    to_trfc(1);
    n_cmp++; if (aref_cnt !== 4'd1) begin n_mis++; $display("FAIL trfc_first_cnt: observed %0d expected 1", aref_cnt); end
    nops(10);
    step(C_AREF, 13'd0, 2'd0);
    n_cmp++; if (err_code !== 3'd4) begin n_mis++; $display("FAIL trfc_gap11: observed %0d expected 4", err_code); end
    n_cmp++; if (aref_cnt !== 4'd1) begin n_mis++; $display("FAIL trfc_gap11_cnt: observed %0d expected 1", aref_cnt); end
    to_trfc(1);
    nops(11);
    step(C_LMR, 13'h037, 2'd0);
    n_cmp++; if (err_code !== 3'd5) begin n_mis++; $display("FAIL lmr_one_aref: observed %0d expected 5", err_code); end
    n_cmp++; if (mode_reg !== 13'd0) begin n_mis++; $display("FAIL lmr_one_aref_mr: observed %h expected 0", mode_reg); end
    to_trfc(1);
    nops(5);
    step(C_LMR, 13'h037, 2'd0);
    n_cmp++; if (err_code !== 3'd4) begin n_mis++; $display("FAIL lmr_short_lowest: observed %0d expected 4", err_code); end
    to_trfc(2);
    nops(11);
    step(C_LMR, 13'h037, 2'd1);
    n_cmp++; if (err_code !== 3'd7) begin n_mis++; $display("FAIL lmr_bad_ba: observed %0d expected 7", err_code); end
    to_trfc(2);
    nops(11);
    step(C_WR, 13'd0, 2'd0);
    n_cmp++; if (err_code !== 3'd7) begin n_mis++; $display("FAIL trfc_wr: observed %0d expected 7", err_code); end
  endtask

  task automatic test_tmrd();
    to_trfc(2);
    nops(11);
    step(C_LMR, 13'h123, 2'd0);
    nops(4);
    step(C_RD, 13'd0, 2'd0);
    n_cmp++; if (err_code !== 3'd6) begin n_mis++; $display("FAIL tmrd_short: observed %0d expected 6", err_code); end
    n_cmp++; if ({init_ok, mode_valid} !== 2'b00) begin n_mis++; $display("FAIL tmrd_short_ok: observed %b expected 00", {init_ok, mode_valid}); end
    n_cmp++; if (mode_reg !== 13'h123) begin n_mis++; $display("FAIL tmrd_mode_reg: observed %h expected 123", mode_reg); end
  endtask

  task automatic test_aref_sat();
    to_trfc(16);
    n_cmp++; if (aref_cnt !== 4'd15) begin n_mis++; $display("FAIL aref_sat: observed %0d expected 15", aref_cnt); end
    n_cmp++; if (init_err !== 1'b0) begin n_mis++; $display("FAIL aref_sat_err: observed %0b expected 0", init_err); end
  endtask

  task automatic test_reset_mid();
    to_trfc(3);
    sys_rst = 1'b1;
    step(C_NOP, 13'd0, 2'd0);
    sys_rst = 1'b0;
    n_cmp++; if ({init_ok, init_err, err_code, aref_cnt, mode_reg, mode_valid} !== 23'd0) begin
      n_mis++; $display("FAIL midrst_clear: observed ok=%0b err=%0b code=%0d cnt=%0d mr=%h mv=%0b expected all 0", init_ok, init_err, err_code, aref_cnt, mode_reg, mode_valid);
    end
    nominal_from_release();
    n_cmp++; if (init_ok !== 1'b1) begin n_mis++; $display("FAIL midrst_ok: observed %0b expected 1", init_ok); end
    n_cmp++; if (aref_cnt !== 4'd6) begin n_mis++; $display("FAIL midrst_cnt: observed %0d expected 6", aref_cnt); end
    n_cmp++; if (init_err !== 1'b0) begin n_mis++; $display("FAIL midrst_err: observed %0b expected 0", init_err); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_pow();
    test_trp();
    test_trfc();
    test_tmrd();
    test_aref_sat();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/sdram_init_checker.md
SDRAM_INIT_CHECKER -- requirements
Module: sdram_init_checker

Interface
REQ-001 Parameter POW_CYC, default 33445: minimum cycles from reset release to the first non-NOP command.
REQ-002 Parameter RP_CYC, default 4: minimum PRE-to-next-command gap in cycles.
REQ-003 Parameter RFC_CYC, default 12: minimum AREF-to-next-command gap in cycles.
REQ-004 Parameter MRD_CYC, default 6: minimum LMR-to-completion gap in cycles.
REQ-005 Parameter AREF_MIN, default 2: minimum number of AREF commands before LMR.
REQ-006 Port sys_clk, input, 1: single clock; all logic on its rising edge.
REQ-007 Port sys_rst, input, 1: one clock; reset is synchronous and active-high.
REQ-008 Port cmd_in, input, 4: monitored {cs_n,ras_n,cas_n,we_n}.
REQ-009 Port addr_in, input, 13: monitored SDRAM address bus.
REQ-010 Port ba_in, input, 2: monitored bank address.
REQ-011 Port init_ok, output, 1: sticky; the init sequence completed legally.
REQ-012 Port init_err, output, 1: sticky; an init violation was detected.
REQ-013 Port err_code, output, 3: code of the first violation; 0 means none.
REQ-014 Port aref_cnt, output, 4: number of AREF commands accepted; saturates at 15.
REQ-015 Port mode_reg, output, 13: addr_in value captured on the accepted LMR.
REQ-016 Port mode_valid, output, 1: mode_reg holds a legally programmed value.

Function
REQ-017 The block SHALL decode commands as follows: NOP 0111; any cmd_in[3]=1 (deselect) is treated as NOP; PRE 0010; AREF 0001; LMR 0000; ACT 0011; RD 0101; WR 0100; BT 0110.
REQ-018 The block SHALL implement these states: CK_POW, CK_PRE, CK_TRP, CK_AREF, CK_TRFC, CK_TMRD, CK_DONE, CK_ERR.
REQ-019 The block SHALL keep a 16-bit saturating gap counter: 1 in the cycle after a non-NOP command is sampled, incremented every cycle after that, and counting from reset release while in CK_POW.
REQ-020 The block SHALL judge a command sampled g cycles after the previous one against the parameter minimum as g >= minimum.
REQ-021 CK_POW: a non-NOP command with gap < POW_CYC SHALL raise code 1; PRE with addr_in[10]=1 SHALL go to CK_TRP; any other command SHALL raise code 2.
REQ-022 CK_TRP: the first non-NOP command SHALL be AREF with gap >= RP_CYC, going to CK_TRFC; a short gap SHALL raise code 3; any other command SHALL raise code 7.
REQ-023 CK_TRFC: a non-NOP command with gap < RFC_CYC SHALL raise code 4.
REQ-024 CK_TRFC: AREF SHALL stay in CK_TRFC and increment aref_cnt.
REQ-025 CK_TRFC: LMR with aref_cnt >= AREF_MIN and ba_in=00 SHALL capture addr_in into mode_reg and go to CK_TMRD.
REQ-026 CK_TRFC: LMR with aref_cnt < AREF_MIN SHALL raise code 5.
REQ-027 CK_TRFC: LMR with ba_in!=00, or any of ACT/RD/WR/BT/PRE, SHALL raise code 7.
REQ-028 The AREF that leaves CK_TRP SHALL also increment aref_cnt.
REQ-029 CK_TMRD: a non-NOP command with gap < MRD_CYC SHALL raise code 6; when gap reaches MRD_CYC with only NOPs, the block SHALL go to CK_DONE.
REQ-030 CK_DONE: init_ok and mode_valid SHALL be 1; all further commands SHALL be ignored.
REQ-031 Raising a violation SHALL set init_err=1, latch err_code, and go to CK_ERR; CK_ERR SHALL ignore all input and hold every output until reset.
REQ-032 Outputs SHALL be registered, updating the cycle after the deciding command or gap cycle; init_ok and init_err SHALL never both be 1.
REQ-033 Where several checks fail on one command, the lowest code number SHALL be reported.
REQ-034 CK_AREF is reserved; any encoding not listed in REQ-018 SHALL recover to CK_POW.

Reset
REQ-035 While sys_rst=1 at a clock edge: state CK_POW, gap counter 0, init_ok=0, init_err=0, err_code=0, aref_cnt=0, mode_reg=0, mode_valid=0.
REQ-036 Reset asserted in any state, including mid-sequence, SHALL abort checking; the power-up count SHALL restart from the first cycle with sys_rst=0.

Verification
REQ-037 Nominal (POW_CYC=20): PRE at 20, AREF×6 at gaps 4/12, LMR addr=0x037 at gap 12, NOPs -> init_ok=1 six cycles after LMR+1, mode_reg=0x037, aref_cnt=6, err_code=0.
REQ-038 PRE at cycle 10 with POW_CYC=20 -> init_err=1, err_code=1 next cycle, no further change.
REQ-039 Second AREF 11 cycles after the first -> err_code=4.
REQ-040 LMR after a single AREF -> err_code=5.
REQ-041 ACT in CK_TRP -> err_code=7.
REQ-042 sys_rst pulse mid-CK_TRFC, then a full nominal sequence -> all outputs cleared, then init_ok=1.
